// File: rtl/shake_pkg.sv
// ---------------------------------------------------------------------------
// shake_pkg
// Shared types and constants for the SHAKE/SHA3 absorb path.
//   mode_t          : message mode carried in the header
//   state_t         : loader FSM states
//   RATE_BYTES      : sponge rate in bytes for each mode
//   DOMAIN_BYTE     : first padding byte (domain separation + first pad bit)
//   words_per_block : number of W-bit words that fill one rate-sized block
// ---------------------------------------------------------------------------
package shake_pkg;

    typedef enum logic [1:0] {
        MODE_SHAKE128 = 2'd0,
        MODE_SHAKE256 = 2'd1,
        MODE_SHA3_256 = 2'd2,
        MODE_SHA3_512 = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PAD  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam int MAX_RATE_BYTES = 168;

    localparam int RATE_BYTES [4] = '{168, 136, 136, 72};

    // SHAKE uses suffix 1111 and SHA3 uses suffix 01, each followed by the
    // first '1' of pad10*1, packed LSB-first into one byte.
    localparam logic [7:0] DOMAIN_BYTE [4] = '{8'h1F, 8'h1F, 8'h06, 8'h06};

    // W/8 divides every rate, so the division is always exact.
    function automatic int words_per_block(input mode_t mode, input int w);
        return RATE_BYTES[mode] / (w / 8);
    endfunction

endpackage

// File: rtl/absorb_sipo.sv
// ---------------------------------------------------------------------------
// absorb_sipo
// Serial-in / parallel-out block buffer for the absorb stage. Message words
// are written at a word index with a per-byte valid mask (invalid bytes are
// stored as zero), and the pad10*1 bytes are OR-ed in on request.
//   clk, rst       : clock, synchronous active-high reset (clears buffer)
//   clear          : synchronous buffer clear
//   wr_en          : write wr_data into word slot wr_idx
//   wr_idx         : word slot inside the block
//   wr_data        : message word, byte 0 at bits [7:0]
//   wr_mask        : per-byte valid mask for wr_data
//   pad_en         : OR padding into the buffer this cycle
//   pad_off        : byte offset receiving the domain byte
//   pad_rate       : rate in bytes; byte pad_rate-1 receives 0x80
//   pad_domain     : domain byte value
//   block_data     : full buffer contents, byte i at bits 8*i +: 8
// ---------------------------------------------------------------------------
module absorb_sipo #(
    parameter int W        = 64,
    parameter int MAX_RATE = 1344,
    parameter int WIDX_W   = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                wr_en,
    input  logic [WIDX_W-1:0]   wr_idx,
    input  logic [W-1:0]        wr_data,
    input  logic [W/8-1:0]      wr_mask,
    input  logic                pad_en,
    input  logic [7:0]          pad_off,
    input  logic [7:0]          pad_rate,
    input  logic [7:0]          pad_domain,
    output logic [MAX_RATE-1:0] block_data
);

    localparam int BPW    = W / 8;
    localparam int NBYTES = MAX_RATE / 8;

    logic [7:0] pad_last;

    // Index of the final byte of the rate, which carries the closing pad bit.
    always_comb begin
        pad_last = pad_rate - 8'd1;
    end

    // Each buffer byte is its own register with a fixed word slot and lane, so
    // the write path is a simple index compare instead of a variable shift.
    for (genvar i = 0; i < NBYTES; i++) begin : g_byte
        localparam int              LANE = i % BPW;
        localparam logic [WIDX_W-1:0] SLOT = WIDX_W'(i / BPW);

        logic [7:0] byte_q;
        logic [7:0] pad_bits;

        // Both pad contributions may land on the same byte when the message
        // ends one byte before the rate, giving 0x9F or 0x86 there.
        always_comb begin
            pad_bits = 8'h00;
            if (pad_off == 8'(i)) begin
                pad_bits = pad_bits | pad_domain;
            end
            if (pad_last == 8'(i)) begin
                pad_bits = pad_bits | 8'h80;
            end
        end

        // Clear wins over write, write over pad; the loader never asks for
        // write and pad in the same cycle.
        always_ff @(posedge clk) begin
            if (rst || clear) begin
                byte_q <= 8'h00;
            end else if (wr_en && (wr_idx == SLOT)) begin
                byte_q <= wr_mask[LANE] ? wr_data[LANE*8 +: 8] : 8'h00;
            end else if (pad_en) begin
                byte_q <= byte_q | pad_bits;
            end
        end

        assign block_data[i*8 +: 8] = byte_q;
    end

endmodule

// File: rtl/shake_absorb_loader.sv
// ---------------------------------------------------------------------------
// shake_absorb_loader
// Input stage of the SHAKE/SHA3 core. Takes a header (mode, byte length),
// collects W-bit message words into a rate-sized block, applies byte-exact
// pad10*1 with the mode's domain byte and offers every full block to the
// permutation over valid/ready.
//   clk, rst                : clock, synchronous active-high reset
//   hdr_valid/hdr_ready     : header handshake
//   hdr_mode, hdr_len       : mode (0..3) and message length in bytes
//   valid_in/ready_out      : message word handshake
//   data_in                 : message word, byte 0 at bits [7:0]
//   block_valid/block_ready : block handshake towards the permutation
//   block_data              : padded block, message byte i at 8*(i mod rate)
//   block_last              : block is the final block of the message
//   block_mode              : mode of the message in flight
//   busy                    : loader is not idle
// ---------------------------------------------------------------------------
module shake_absorb_loader
    import shake_pkg::*;
#(
    parameter int W        = 64,
    parameter int LEN_W    = 32,
    parameter int MAX_RATE = 1344
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hdr_valid,
    output logic                hdr_ready,
    input  logic [1:0]          hdr_mode,
    input  logic [LEN_W-1:0]    hdr_len,
    input  logic                valid_in,
    output logic                ready_out,
    input  logic [W-1:0]        data_in,
    output logic                block_valid,
    input  logic                block_ready,
    output logic [MAX_RATE-1:0] block_data,
    output logic                block_last,
    output logic [1:0]          block_mode,
    output logic                busy
);

    localparam int BPW    = W / 8;
    localparam int WIDX_W = $clog2(MAX_RATE / W) + 1;

    state_t              state_q, state_d;
    mode_t               mode_q, mode_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [WIDX_W-1:0]   idx_q, idx_d;
    logic                last_q, last_d;

    logic [LEN_W-1:0]    take;
    logic [LEN_W-1:0]    rem_after;
    logic [WIDX_W-1:0]   idx_after;
    logic [BPW-1:0]      byte_mask;
    logic [7:0]          rate_cur;
    logic [7:0]          off_cur;
    logic [7:0]          domain_cur;
    logic [WIDX_W-1:0]   wpb_cur;

    logic                buf_clear;
    logic                buf_wr;
    logic                buf_pad;
    logic [MAX_RATE-1:0] buf_data;

    // Per-word bookkeeping: bytes consumed by this word (never more than what
    // is left, so rem cannot wrap) and the resulting counters.
    always_comb begin
        take      = (rem_q < LEN_W'(BPW)) ? rem_q : LEN_W'(BPW);
        rem_after = rem_q - take;
        idx_after = idx_q + WIDX_W'(1);
    end

    // A lane is valid while its byte position in the word is below rem; on
    // the final partial word this drops the trailing garbage bytes.
    for (genvar b = 0; b < BPW; b++) begin : g_mask
        assign byte_mask[b] = (LEN_W'(b) < rem_q);
    end

    // Mode-dependent constants for the message in flight.
    always_comb begin
        rate_cur   = 8'(RATE_BYTES[mode_q]);
        domain_cur = DOMAIN_BYTE[mode_q];
        wpb_cur    = WIDX_W'(words_per_block(mode_q, W));
    end

    // Offset of the first pad byte inside the final block. Constant divisors
    // per mode keep this to fixed-modulus logic.
    always_comb begin
        off_cur = 8'h00;
        case (mode_q)
            MODE_SHAKE128:                off_cur = 8'(len_q % LEN_W'(RATE_BYTES[0]));
            MODE_SHAKE256, MODE_SHA3_256: off_cur = 8'(len_q % LEN_W'(RATE_BYTES[1]));
            default:                      off_cur = 8'(len_q % LEN_W'(RATE_BYTES[3]));
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Header, length and block counters. Reset drops any message in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_SHAKE128;
            len_q  <= '0;
            rem_q  <= '0;
            idx_q  <= '0;
            last_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            len_q  <= len_d;
            rem_q  <= rem_d;
            idx_q  <= idx_d;
            last_q <= last_d;
        end
    end

    // Next-state and buffer control. A message whose length is an exact
    // multiple of the rate fills its last block from data alone, so it goes
    // to HOLD as a non-final block and the padding follows in its own block.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        len_d     = len_q;
        rem_d     = rem_q;
        idx_d     = idx_q;
        last_d    = last_q;
        buf_clear = 1'b0;
        buf_wr    = 1'b0;
        buf_pad   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hdr_valid) begin
                    mode_d  = mode_t'(hdr_mode);
                    len_d   = hdr_len;
                    rem_d   = hdr_len;
                    idx_d   = '0;
                    last_d  = 1'b0;
                    state_d = (hdr_len == '0) ? ST_PAD : ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (valid_in) begin
                    buf_wr = 1'b1;
                    rem_d  = rem_after;
                    idx_d  = idx_after;
                    if ((rem_after == '0) && (off_cur != 8'h00)) begin
                        state_d = ST_PAD;
                    end else if (idx_after == wpb_cur) begin
                        last_d  = 1'b0;
                        state_d = ST_HOLD;
                    end
                end
            end

            ST_PAD: begin
                buf_pad = 1'b1;
                last_d  = 1'b1;
                state_d = ST_HOLD;
            end

            ST_HOLD: begin
                if (block_ready) begin
                    buf_clear = 1'b1;
                    if (last_q) begin
                        state_d = ST_IDLE;
                    end else if (rem_q != '0) begin
                        idx_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_PAD;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    absorb_sipo #(
        .W        (W),
        .MAX_RATE (MAX_RATE),
        .WIDX_W   (WIDX_W)
    ) u_sipo (
        .clk        (clk),
        .rst        (rst),
        .clear      (buf_clear),
        .wr_en      (buf_wr),
        .wr_idx     (idx_q),
        .wr_data    (data_in),
        .wr_mask    (byte_mask),
        .pad_en     (buf_pad),
        .pad_off    (off_cur),
        .pad_rate   (rate_cur),
        .pad_domain (domain_cur),
        .block_data (buf_data)
    );

    // Outputs decode from registered state only; reset forces them all low
    // for as long as it is asserted.
    always_comb begin
        hdr_ready   = !rst && (state_q == ST_IDLE);
        ready_out   = !rst && (state_q == ST_LOAD);
        block_valid = !rst && (state_q == ST_HOLD);
        block_last  = !rst && (state_q == ST_HOLD) && last_q;
        busy        = !rst && (state_q != ST_IDLE);
        block_mode  = rst ? 2'b00 : 2'(mode_q);
        block_data  = rst ? '0 : buf_data;
    end

endmodule

// File: tb/tb_shake_absorb_loader.sv
// ---------------------------------------------------------------------------
// tb_shake_absorb_loader
// Directed self-checking bench for shake_absorb_loader (W=64). Messages are
// streamed through the header/word/block handshakes; every block is compared
// against a padding model and against hand-computed byte values.
// ---------------------------------------------------------------------------
module tb_shake_absorb_loader;

    localparam int W        = 64;
    localparam int LEN_W    = 32;
    localparam int MAX_RATE = 1344;
    localparam int BPW      = W / 8;
    localparam int NCHUNK   = MAX_RATE / 64;

    localparam int         RATE_TAB [4] = '{168, 136, 136, 72};
    localparam logic [7:0] DOM_TAB  [4] = '{8'h1F, 8'h1F, 8'h06, 8'h06};

    logic                clk = 1'b0;
    logic                rst;
    logic                hdr_valid;
    logic                hdr_ready;
    logic [1:0]          hdr_mode;
    logic [LEN_W-1:0]    hdr_len;
    logic                valid_in;
    logic                ready_out;
    logic [W-1:0]        data_in;
    logic                block_valid;
    logic                block_ready;
    logic [MAX_RATE-1:0] block_data;
    logic                block_last;
    logic [1:0]          block_mode;
    logic                busy;

    int assert_count = 0;
    int fail_count   = 0;

    logic [MAX_RATE-1:0] got_blk [4];

    always #5 clk = ~clk;

    shake_absorb_loader #(
        .W        (W),
        .LEN_W    (LEN_W),
        .MAX_RATE (MAX_RATE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hdr_valid   (hdr_valid),
        .hdr_ready   (hdr_ready),
        .hdr_mode    (hdr_mode),
        .hdr_len     (hdr_len),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .data_in     (data_in),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .block_data  (block_data),
        .block_last  (block_last),
        .block_mode  (block_mode),
        .busy        (busy)
    );

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Message byte values stay in 1..150, so 0xAA never appears as data.
    function automatic logic [7:0] msg_byte(input int i, input int seed);
        return 8'((i % 100) + 1 + seed);
    endfunction

    // Word w of the message; bytes past the end carry 0xAA garbage.
    function automatic logic [W-1:0] make_word(input int len, input int seed, input int w);
        logic [W-1:0] r;
        r = '0;
        for (int b = 0; b < BPW; b++) begin
            r[b*8 +: 8] = ((w*BPW + b) < len) ? msg_byte(w*BPW + b, seed) : 8'hAA;
        end
        return r;
    endfunction

    // Expected block k of a message: message bytes, zeros, and pad10*1 on the
    // final block.
    function automatic logic [MAX_RATE-1:0] exp_block(input int mode, input int len, input int seed, input int k);
        logic [MAX_RATE-1:0] r;
        int rate;
        int off;
        rate = RATE_TAB[mode];
        r    = '0;
        for (int j = 0; j < rate; j++) begin
            if ((k*rate + j) < len) begin
                r[j*8 +: 8] = msg_byte(k*rate + j, seed);
            end
        end
        if (k == len / rate) begin
            off = len % rate;
            r[off*8 +: 8]      = r[off*8 +: 8] | DOM_TAB[mode];
            r[(rate-1)*8 +: 8] = r[(rate-1)*8 +: 8] | 8'h80;
        end
        return r;
    endfunction

    function automatic logic [7:0] byte_of(input int k, input int i);
        logic [MAX_RATE-1:0] b;
        b = got_blk[k];
        return b[i*8 +: 8];
    endfunction

    // Drives one whole message and checks each block as it appears. With
    // stall > 0 the first block is held back that many cycles while valid_in
    // toggles with junk data.
    task automatic applyStimulus(input int mode, input int len, input int seed, input int stall, input int tid);
        int rate, n_words, n_blocks, word_idx, blk, latency, iter, wait_cnt;
        logic [MAX_RATE-1:0] exp;
        rate     = RATE_TAB[mode];
        n_words  = (len + BPW - 1) / BPW;
        n_blocks = len / rate + 1;
        word_idx = 0;
        blk      = 0;
        latency  = 0;
        iter     = 0;

        @(negedge clk);
        hdr_valid = 1'b1;
        hdr_mode  = 2'(mode);
        hdr_len   = LEN_W'(len);
        wait_cnt  = 0;
        while (!hdr_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        checkOutput($sformatf("t%0d_hdr_ready", tid), 64'(hdr_ready), 64'd1);
        @(posedge clk);
        latency = 1;
        @(negedge clk);
        hdr_valid = 1'b0;
        checkOutput($sformatf("t%0d_hdr_ready_low", tid), 64'(hdr_ready), 64'd0);
        checkOutput($sformatf("t%0d_first_ready", tid), 64'(ready_out), 64'(len > 0));
        checkOutput($sformatf("t%0d_busy", tid), 64'(busy), 64'd1);

        while (blk < n_blocks && iter < 1000) begin
            iter++;
            if (ready_out) begin
                checkOutput($sformatf("t%0d_ready_in_range", tid), 64'(ready_out), 64'(word_idx < n_words));
                valid_in = 1'b1;
                data_in  = make_word(len, seed, word_idx);
                @(posedge clk);
                word_idx++;
                latency = 1;
                @(negedge clk);
                valid_in = 1'b0;
            end else if (block_valid) begin
                checkOutput($sformatf("t%0d_b%0d_latency", tid, blk), 64'(latency),
                            (blk == n_blocks - 1) ? 64'd2 : 64'd1);
                exp = exp_block(mode, len, seed, blk);
                for (int c = 0; c < NCHUNK; c++) begin
                    checkOutput($sformatf("t%0d_b%0d_chunk%0d", tid, blk, c),
                                block_data[c*64 +: 64], exp[c*64 +: 64]);
                end
                checkOutput($sformatf("t%0d_b%0d_last", tid, blk), 64'(block_last), 64'(blk == n_blocks - 1));
                checkOutput($sformatf("t%0d_b%0d_mode", tid, blk), 64'(block_mode), 64'(mode));
                got_blk[blk] = block_data;
                if (stall > 0 && blk == 0) begin
                    for (int s = 0; s < stall; s++) begin
                        valid_in = ((s % 2) == 0);
                        data_in  = 64'hDEAD_BEEF_CAFE_F00D;
                        @(posedge clk);
                        @(negedge clk);
                        checkOutput($sformatf("t%0d_stall%0d_valid", tid, s), 64'(block_valid), 64'd1);
                        checkOutput($sformatf("t%0d_stall%0d_ready", tid, s), 64'(ready_out), 64'd0);
                        checkOutput($sformatf("t%0d_stall%0d_hdr", tid, s), 64'(hdr_ready), 64'd0);
                        checkOutput($sformatf("t%0d_stall%0d_stable", tid, s),
                                    64'(block_data === got_blk[0]), 64'd1);
                    end
                    valid_in = 1'b0;
                end
                block_ready = 1'b1;
                @(posedge clk);
                latency = 1;
                blk++;
                @(negedge clk);
                block_ready = 1'b0;
            end else begin
                @(posedge clk);
                latency++;
                @(negedge clk);
            end
        end

        checkOutput($sformatf("t%0d_blocks", tid), 64'(blk), 64'(n_blocks));
        checkOutput($sformatf("t%0d_words", tid), 64'(word_idx), 64'(n_words));
        checkOutput($sformatf("t%0d_idle_hdr_ready", tid), 64'(hdr_ready), 64'd1);
        checkOutput($sformatf("t%0d_idle_busy", tid), 64'(busy), 64'd0);
    endtask

    initial begin
        int aa_count;
        rst         = 1'b1;
        hdr_valid   = 1'b0;
        hdr_mode    = 2'd0;
        hdr_len     = '0;
        valid_in    = 1'b0;
        data_in     = '0;
        block_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_hdr_ready", 64'(hdr_ready), 64'd0);
        checkOutput("rst_ready_out", 64'(ready_out), 64'd0);
        checkOutput("rst_block_valid", 64'(block_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_hdr_ready", 64'(hdr_ready), 64'd1);
        checkOutput("post_rst_data_zero", 64'(block_data == '0), 64'd1);

        // 1: empty SHAKE128 message, pad-only block
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("t1_byte0", 64'(byte_of(0, 0)), 64'h1F);
        checkOutput("t1_byte1", 64'(byte_of(0, 1)), 64'h00);
        checkOutput("t1_byte167", 64'(byte_of(0, 167)), 64'h80);

        // 2: SHAKE256 exactly one rate, then a pad-only block
        applyStimulus(1, 136, 0, 0, 2);
        checkOutput("t2_b0_byte0", 64'(byte_of(0, 0)), 64'h01);
        checkOutput("t2_b0_byte135", 64'(byte_of(0, 135)), 64'h24);
        checkOutput("t2_b1_byte0", 64'(byte_of(1, 0)), 64'h1F);
        checkOutput("t2_b1_byte135", 64'(byte_of(1, 135)), 64'h80);

        // 3: SHA3-512, message ends one byte before the rate
        applyStimulus(3, 71, 0, 0, 3);
        checkOutput("t3_byte70", 64'(byte_of(0, 70)), 64'h47);
        checkOutput("t3_byte71", 64'(byte_of(0, 71)), 64'h86);

        // 4: SHAKE128 two blocks, partial final word with 0xAA garbage
        applyStimulus(0, 203, 0, 0, 4);
        checkOutput("t4_b0_byte167", 64'(byte_of(0, 167)), 64'h44);
        checkOutput("t4_b1_byte0", 64'(byte_of(1, 0)), 64'h45);
        checkOutput("t4_b1_byte34", 64'(byte_of(1, 34)), 64'h03);
        checkOutput("t4_b1_byte35", 64'(byte_of(1, 35)), 64'h1F);
        checkOutput("t4_b1_byte36", 64'(byte_of(1, 36)), 64'h00);
        checkOutput("t4_b1_byte167", 64'(byte_of(1, 167)), 64'h80);
        aa_count = 0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < MAX_RATE / 8; i++) begin
                if (byte_of(k, i) == 8'hAA) aa_count++;
            end
        end
        checkOutput("t4_no_aa", 64'(aa_count), 64'd0);

        // 5: back-pressure in HOLD with valid_in toggling
        applyStimulus(3, 150, 5, 10, 5);
        checkOutput("t5_b2_byte0", 64'(byte_of(2, 0)), 64'h32);
        checkOutput("t5_b2_byte5", 64'(byte_of(2, 5)), 64'h37);
        checkOutput("t5_b2_byte6", 64'(byte_of(2, 6)), 64'h06);
        checkOutput("t5_b2_byte71", 64'(byte_of(2, 71)), 64'h80);

        // 6: reset in the middle of LOAD, then a short SHA3-256 message
        @(negedge clk);
        hdr_valid = 1'b1;
        hdr_mode  = 2'd1;
        hdr_len   = LEN_W'(100);
        @(posedge clk);
        @(negedge clk);
        hdr_valid = 1'b0;
        for (int w = 0; w < 3; w++) begin
            valid_in = 1'b1;
            data_in  = make_word(100, 0, w);
            @(posedge clk);
            @(negedge clk);
        end
        valid_in = 1'b0;
        checkOutput("t6_ready_before", 64'(ready_out), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_hdr_ready", 64'(hdr_ready), 64'd0);
        checkOutput("t6_rst_ready_out", 64'(ready_out), 64'd0);
        checkOutput("t6_rst_busy", 64'(busy), 64'd0);
        checkOutput("t6_rst_block_valid", 64'(block_valid), 64'd0);
        checkOutput("t6_rst_block_mode", 64'(block_mode), 64'd0);
        checkOutput("t6_rst_data_zero", 64'(block_data == '0), 64'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("t6_after_hdr_ready", 64'(hdr_ready), 64'd1);
        checkOutput("t6_after_busy", 64'(busy), 64'd0);
        checkOutput("t6_after_ready_out", 64'(ready_out), 64'd0);
        checkOutput("t6_after_block_mode", 64'(block_mode), 64'd0);
        checkOutput("t6_after_data_zero", 64'(block_data == '0), 64'd1);
        applyStimulus(2, 5, 0, 0, 6);
        checkOutput("t6_byte4", 64'(byte_of(0, 4)), 64'h05);
        checkOutput("t6_byte5", 64'(byte_of(0, 5)), 64'h06);
        checkOutput("t6_byte135", 64'(byte_of(0, 135)), 64'h80);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

    // Hard stop in case a handshake never completes.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

endmodule
